// File: rtl/synch_fifo_pkg.sv
// -----------------------------------------------------------------------------
// synch_fifo_pkg
// Shared definitions for the `synch` FIFO and the logic that sits around it.
//   arb_state_e      : write-arbiter FSM states (IDLE, BURST)
//   DEF_DEPTH        : default FIFO depth shared with `synch` and its bench
//   DEF_DATA_WIDTH   : default FIFO word width shared with `synch` and its bench
// -----------------------------------------------------------------------------
package synch_fifo_pkg;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 12;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage : synch_fifo_pkg

// File: rtl/synch_fifo_wr_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the request vector
// starting one position after last_id, wrapping modulo N, and returns the
// first requester found.
// Ports:
//   req      in  N     request vector
//   last_id  in  ID_W  index granted most recently (search starts after it)
//   found    out 1     at least one request bit set
//   idx      out ID_W  index of the winning requester (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_id,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // cand[gi] is the requester sitting gi+1 places after last_id.
    logic [ID_W-1:0] cand [N];
    logic [N-1:0]    hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            // One extra bit so last_id + offset never overflows before the wrap.
            logic [ID_W:0] sum;
            assign sum        = {1'b0, last_id} + (ID_W+1)'(gi + 1);
            assign cand[gi]   = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N))
                                                      : sum[ID_W-1:0];
            assign hit[gi]    = req[cand[gi]];
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        found = |hit;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule : rr_pick

// File: rtl/synch_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// synch_fifo_wr_arb
// Round-robin write arbiter letting NUM_REQ valid/ready producers share the
// single write port of one `synch` FIFO. Grants are per burst: a burst ends on
// the owner's last marker, after MAX_BURST beats, or when the owner drops
// valid. Each arbitration costs one IDLE bubble cycle.
// Ports:
//   clk_i            in  1                   clock, rising edge
//   rst_i            in  1                   synchronous reset, active low
//   req_valid_i      in  NUM_REQ             per-requester valid
//   req_data_i       in  NUM_REQ*DATA_WIDTH  requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i       in  NUM_REQ             per-requester end-of-burst marker
//   req_ready_o      out NUM_REQ             per-requester accept, one-hot or zero
//   fifo_full_i      in  1                   FIFO full_o
//   fifo_overflow_i  in  1                   FIFO overflow_o
//   fifo_wr_en_o     out 1                   FIFO wr_en_i
//   fifo_wdata_o     out DATA_WIDTH          FIFO wdata_i (0 when not writing)
//   grant_id_o       out ID_W                current owner, valid while busy_o=1
//   busy_o           out 1                   1 while a burst is granted
//   err_o            out 1                   sticky overflow seen, cleared by reset
// -----------------------------------------------------------------------------
module synch_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = synch_fifo_pkg::DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_overflow_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o,
    output logic                          err_o
);

    import synch_fifo_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e             state_reg;
    logic [ID_W-1:0]        grant_id_reg;
    logic [ID_W-1:0]        last_id_reg;
    logic [CNT_W-1:0]       burst_cnt_reg;
    logic                   err_reg;

    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic                   owner_valid;
    logic                   owner_last;
    logic                   open;
    logic                   beat;
    logic                   burst_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req     (req_valid_i),
        .last_id (last_id_reg),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    assign owner_valid = req_valid_i[grant_id_reg];
    assign owner_last  = req_last_i[grant_id_reg];
    assign burst_full  = (burst_cnt_reg == CNT_W'(MAX_BURST - 1));

    // The write port is only open in BURST with room in the FIFO. Gating with
    // rst_i keeps the reset cycle itself write-free when reset hits mid-burst.
    assign open = (state_reg == BURST) && rst_i && !fifo_full_i;
    assign beat = open && owner_valid;

    always_comb begin
        req_ready_o = '0;
        if (open) begin
            req_ready_o[grant_id_reg] = 1'b1;
        end
    end

    assign fifo_wr_en_o = beat;
    assign fifo_wdata_o = beat ? data_arr[grant_id_reg] : '0;
    assign grant_id_o   = grant_id_reg;
    assign busy_o       = (state_reg == BURST);
    assign err_o        = err_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            // Start the search just after the top index so requester 0 wins first.
            last_id_reg   <= ID_W'(NUM_REQ - 1);
            burst_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (fifo_overflow_i) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_id_reg  <= pick_idx;
                        last_id_reg   <= pick_idx;
                        burst_cnt_reg <= '0;
                        state_reg     <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        // Owner let go early; hand the port back.
                        state_reg <= IDLE;
                    end else if (beat) begin
                        burst_cnt_reg <= burst_cnt_reg + 1'b1;
                        if (owner_last || burst_full) begin
                            state_reg <= IDLE;
                        end
                    end
                    // Valid but full: stall with state and count held.
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule : synch_fifo_wr_arb

// File: tb/tb_synch_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_synch_fifo_wr_arb
// Bench for synch_fifo_wr_arb. Producers are modelled as queues of words, the
// FIFO as a bounded queue, and the arbiter by a grant-level reference model
// (owner, beats taken this grant, last winner).
// -----------------------------------------------------------------------------
module tb_synch_fifo_wr_arb;

    localparam int N     = 4;
    localparam int W     = 12;
    localparam int MB    = 4;
    localparam int DEPTH = synch_fifo_pkg::DEF_DEPTH;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_overflow;
    logic             wr_en;
    logic [W-1:0]     wdata;
    logic [1:0]       grant;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    synch_fifo_wr_arb #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .fifo_full_i     (fifo_full),
        .fifo_overflow_i (fifo_overflow),
        .fifo_wr_en_o    (wr_en),
        .fifo_wdata_o    (wdata),
        .grant_id_o      (grant),
        .busy_o          (busy),
        .err_o           (err)
    );

    int checks   = 0;
    int failures = 0;

    // Producer and FIFO stand-ins
    item_t        src_q [N][$];
    logic [N-1:0] hold = '0;
    logic [W-1:0] fifo_q [$];
    int           drain_pct = 0;
    int           wr_count  = 0;

    // Reference model of grant ownership
    logic m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_last  = N - 1;
    int   m_cnt   = 0;

    // Per-cycle expectations and observations
    logic [N-1:0] e_ready, o_ready;
    logic         e_wr, o_wr, e_busy, o_busy, o_err;
    logic [W-1:0] e_wd, o_wd;
    int           e_grant;
    logic [1:0]   o_grant;

    function automatic int rr_next(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] word(input int id, input int n);
        return W'((id << 8) | n);
    endfunction

    task automatic load(input int id, input int count, input bit last_on_end);
        item_t it;
        for (int n = 0; n < count; n++) begin
            it.data = word(id, n);
            it.last = last_on_end && (n == count - 1);
            src_q[id].push_back(it);
        end
    endtask

    // One clock: drive producers, sample at negedge, advance models at posedge.
    task automatic step();
        int w;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && !hold[k]) begin
                req_valid[k]         = 1'b1;
                req_data[k*W +: W]   = src_q[k][0].data;
                req_last[k]          = src_q[k][0].last;
            end else begin
                req_valid[k]         = 1'b0;
                req_data[k*W +: W]   = W'($urandom);
                req_last[k]          = 1'b0;
            end
        end
        fifo_full = (fifo_q.size() >= DEPTH);
        @(negedge clk);
        e_ready = '0;
        e_wr    = 1'b0;
        e_wd    = '0;
        if (m_busy && rst_n && !fifo_full) begin
            e_ready[m_owner] = 1'b1;
            if (req_valid[m_owner]) begin
                e_wr = 1'b1;
                e_wd = req_data[m_owner*W +: W];
            end
        end
        e_busy  = m_busy;
        e_grant = m_owner;
        o_ready = req_ready;
        o_wr    = wr_en;
        o_wd    = wdata;
        o_busy  = busy;
        o_grant = grant;
        o_err   = err;
        if (o_wr) $display("[%0t] write id=%0d data=%h", $time, o_grant, o_wd);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        end else if (!m_busy) begin
            w = rr_next(m_last, req_valid);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_last = w; m_cnt = 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 1'b0;
        end else if (e_wr) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) m_busy = 1'b0;
        end
        if (o_wr) begin
            fifo_q.push_back(o_wd);
            wr_count++;
        end
        for (int k = 0; k < N; k++) begin
            if (o_ready[k] && req_valid[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        if (fifo_q.size() > 0 && $urandom_range(99) < drain_pct) void'(fifo_q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) src_q[k].delete();
        hold  = '0;
        rst_n = 1'b0;
        step();
        step();
        fifo_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fifo_overflow = 1'b0;
        do_reset();
        step();
        checks++; if (o_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b want=0", o_ready); end
        checks++; if (o_wr !== 1'b0)  begin failures++; $display("FAIL reset_wr got=%b want=0", o_wr); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", o_err); end
        checks++; if (o_grant !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d want=0", o_grant); end
    endtask

    task automatic test_single();
        logic [W-1:0] exp_words [3];
        logic [W-1:0] got;
        exp_words[0] = word(1, 0); exp_words[1] = word(1, 1); exp_words[2] = word(1, 2);
        do_reset();
        drain_pct = 0;
        load(1, 3, 1'b1);
        step();
        checks++; if (o_wr !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL single_bubble got wr=%b busy=%b want wr=0 busy=0", o_wr, o_busy); end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (o_wr !== 1'b1 || o_grant !== 2'd1 || o_wd !== exp_words[n]) begin
                failures++;
                $display("FAIL single_beat%0d got wr=%b id=%0d data=%h want wr=1 id=1 data=%h", n, o_wr, o_grant, o_wd, exp_words[n]);
            end
        end
        step();
        checks++; if (o_busy !== 1'b0 || o_wr !== 1'b0) begin failures++; $display("FAIL single_end got busy=%b wr=%b want 0 0", o_busy, o_wr); end
        checks++; if (fifo_q.size() != 3) begin failures++; $display("FAIL single_count got=%0d want=3", fifo_q.size()); end
        for (int n = 0; n < 3 && fifo_q.size() > 0; n++) begin
            got = fifo_q.pop_front();
            checks++; if (got !== exp_words[n]) begin failures++; $display("FAIL single_read%0d got=%h want=%h", n, got, exp_words[n]); end
        end
    endtask

    task automatic test_round_robin();
        int g, seq;
        do_reset();
        drain_pct = 100;
        for (int k = 0; k < N; k++) load(k, 8, 1'b0);
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (i % 5 == 0) begin
                if (o_wr !== 1'b0 || o_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_bubble cycle=%0d got wr=%b busy=%b want 0 0", i, o_wr, o_busy);
                end
            end else begin
                g   = (i / 5) % N;
                seq = (i / 5) / N * MB + (i % 5 - 1);
                if (o_wr !== 1'b1 || o_grant !== 2'(g) || o_wd !== word(g, seq)) begin
                    failures++;
                    $display("FAIL rr_beat cycle=%0d got wr=%b id=%0d data=%h want wr=1 id=%0d data=%h", i, o_wr, o_grant, o_wd, g, word(g, seq));
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] got;
        do_reset();
        drain_pct = 0;
        load(0, 20, 1'b0);
        wr_count = 0;
        for (int i = 0; i < 40; i++) step();
        checks++; if (wr_count != DEPTH) begin failures++; $display("FAIL fill_writes got=%0d want=%0d", wr_count, DEPTH); end
        checks++; if (o_ready[0] !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL fill_stall got ready0=%b busy=%b want 0 1", o_ready[0], o_busy); end
        for (int n = 0; n < 2; n++) begin
            got = fifo_q.pop_front();
            checks++; if (got !== word(0, n)) begin failures++; $display("FAIL fill_read%0d got=%h want=%h", n, got, word(0, n)); end
        end
        wr_count = 0;
        for (int i = 0; i < 10; i++) step();
        checks++; if (wr_count != 2) begin failures++; $display("FAIL fill_refill got=%0d want=2", wr_count); end
        checks++; if (fifo_q[fifo_q.size()-1] !== word(0, 17)) begin failures++; $display("FAIL fill_tail got=%h want=%h", fifo_q[fifo_q.size()-1], word(0, 17)); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL fill_err got=%b want=0", o_err); end
    endtask

    task automatic test_early_release();
        do_reset();
        drain_pct = 100;
        load(2, 5, 1'b0);
        load(3, 3, 1'b1);
        step();
        checks++; if (o_wr !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL early_bubble got wr=%b busy=%b want 0 0", o_wr, o_busy); end
        for (int n = 0; n < 2; n++) begin
            step();
            checks++;
            if (o_wr !== 1'b1 || o_grant !== 2'd2 || o_wd !== word(2, n)) begin
                failures++;
                $display("FAIL early_beat%0d got wr=%b id=%0d data=%h want wr=1 id=2 data=%h", n, o_wr, o_grant, o_wd, word(2, n));
            end
        end
        hold[2] = 1'b1;
        step();
        checks++; if (o_wr !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL early_drop got wr=%b busy=%b want 0 1", o_wr, o_busy); end
        step();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL early_idle got busy=%b want 0", o_busy); end
        step();
        checks++; if (o_wr !== 1'b1 || o_grant !== 2'd3 || o_wd !== word(3, 0)) begin failures++; $display("FAIL early_next got wr=%b id=%0d data=%h want wr=1 id=3 data=%h", o_wr, o_grant, o_wd, word(3, 0)); end
        checks++; if (src_q[2].size() != 3) begin failures++; $display("FAIL early_accepted got_left=%0d want_left=3", src_q[2].size()); end
        hold = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drain_pct = 100;
        load(3, 4, 1'b0);
        step();
        step();
        checks++; if (o_wr !== 1'b1 || o_grant !== 2'd3) begin failures++; $display("FAIL midrst_beat1 got wr=%b id=%0d want wr=1 id=3", o_wr, o_grant); end
        rst_n = 1'b0;
        step();
        checks++; if (o_wr !== 1'b0 || o_ready !== '0) begin failures++; $display("FAIL midrst_gate got wr=%b ready=%b want 0 0", o_wr, o_ready); end
        load(0, 2, 1'b1);
        step();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", o_busy); end
        rst_n = 1'b1;
        step();
        step();
        checks++; if (o_wr !== 1'b1 || o_grant !== 2'd0 || o_wd !== word(0, 0)) begin failures++; $display("FAIL midrst_first got wr=%b id=%0d data=%h want wr=1 id=0 data=%h", o_wr, o_grant, o_wd, word(0, 0)); end
    endtask

    task automatic test_overflow();
        do_reset();
        fifo_overflow = 1'b1;
        step();
        fifo_overflow = 1'b0;
        step();
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", o_err); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", o_err); end
        do_reset();
        step();
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", o_err); end
    endtask

    task automatic test_random();
        item_t it;
        int    len;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 100 == 0) drain_pct = $urandom_range(90, 20);
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(3) == 0) begin
                    len = $urandom_range(7, 1);
                    for (int n = 0; n < len; n++) begin
                        it.data = W'($urandom);
                        it.last = (n == len - 1) && ($urandom_range(3) != 0);
                        src_q[k].push_back(it);
                    end
                end
                hold[k] = ($urandom_range(19) == 0);
            end
            step();
            checks++; if (o_ready !== e_ready) begin failures++; $display("FAIL rand_ready cycle=%0d got=%b want=%b", cyc, o_ready, e_ready); end
            checks++; if (o_wr !== e_wr) begin failures++; $display("FAIL rand_wr cycle=%0d got=%b want=%b", cyc, o_wr, e_wr); end
            checks++; if (o_wd !== e_wd) begin failures++; $display("FAIL rand_wdata cycle=%0d got=%h want=%h", cyc, o_wd, e_wd); end
            checks++; if (o_busy !== e_busy) begin failures++; $display("FAIL rand_busy cycle=%0d got=%b want=%b", cyc, o_busy, e_busy); end
            if (e_busy) begin
                checks++; if (o_grant !== 2'(e_grant)) begin failures++; $display("FAIL rand_grant cycle=%0d got=%0d want=%0d", cyc, o_grant, e_grant); end
            end
            checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL rand_err cycle=%0d got=%b want=0", cyc, o_err); end
        end
        hold = '0;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        fifo_full     = 1'b0;
        fifo_overflow = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fill();
        test_early_release();
        test_reset_mid_burst();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_synch_fifo_wr_arb
